// File: rtl/pad_sensor_frontend.sv
// Drum-pad sensor front end: per-zone sync/debounce/pulse-stretch, per-pad hit
// events with fixed priority, and target-word decode into pad LED drives.

module pad_sensor_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 2500000
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic raw,
  output logic held
);
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LD = 24'(HOLD_CYCLES);

  logic        s1_q, s1_d, s2_q, s2_d;
  logic        stable_q, stable_d;
  logic [23:0] dcnt_q, dcnt_d;
  logic [23:0] hold_q, hold_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    dcnt_d   = '0;
    // The edge that accepts a new level also leaves the counter cleared.
    if (s2_q != stable_q) begin
      if (dcnt_q == DB_LAST) stable_d = s2_q;
      else                   dcnt_d   = dcnt_q + 24'd1;
    end
    hold_d = (hold_q != '0) ? hold_q - 24'd1 : '0;
    if (stable_q && !stable_d) hold_d = HOLD_LD;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
      dcnt_q   <= '0;
      hold_q   <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      hold_q   <= hold_d;
    end
  end

  assign held = stable_q & (hold_q == '0);
endmodule

module pad_sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 2500000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [14:0] iSENSOR_RAW,
  input  logic [31:0] iOUT_GAME,
  output logic [31:0] oSENSOR,
  output logic        oHIT_STB,
  output logic [1:0]  oHIT_PAD,
  output logic        oHIT_CENTER,
  output logic [2:0]  oLED
);
  logic [14:0] held;
  logic [14:0] sens_q, sens_d;
  logic [2:0]  hitprev_q, hitprev_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  cen_q, cen_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [2:0]  led_q, led_d;
  logic [2:0]  hit, rise, drain, centre;
  logic        unused_game;

  for (genvar b = 0; b < 15; b++) begin : g_bit
    pad_sensor_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_bit (
      .iVGA_CLK(iVGA_CLK),
      .iRST_n  (iRST_n),
      .raw     (iSENSOR_RAW[b]),
      .held    (held[b])
    );
  end

  // Index 0 is pad 1 (bits 14:10); bit 4 of each group is the centre zone.
  assign hit    = {~&sens_q[4:0], ~&sens_q[9:5], ~&sens_q[14:10]};
  assign centre = {sens_q[4], sens_q[9], sens_q[14]};
  assign rise   = hit & ~hitprev_q;

  always_comb begin
    drain = 3'b000;
    if      (pend_q[0]) drain = 3'b001;
    else if (pend_q[1]) drain = 3'b010;
    else if (pend_q[2]) drain = 3'b100;
  end

  always_comb begin
    sens_d    = held;
    hitprev_d = hit;
    // A rise on the same edge as its own drain re-arms the pad.
    pend_d    = (pend_q & ~drain) | rise;
    cen_d     = (rise & ~centre) | (~rise & cen_q);
    tgt_d     = iOUT_GAME[2:0];
    led_d     = ~tgt_q & ~hit;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sens_q    <= '1;
      hitprev_q <= '0;
      pend_q    <= '0;
      cen_q     <= '0;
      tgt_q     <= 3'b111;
      led_q     <= '0;
    end else begin
      sens_q    <= sens_d;
      hitprev_q <= hitprev_d;
      pend_q    <= pend_d;
      cen_q     <= cen_d;
      tgt_q     <= tgt_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    oHIT_PAD = 2'd0;
    if      (drain[0]) oHIT_PAD = 2'd1;
    else if (drain[1]) oHIT_PAD = 2'd2;
    else if (drain[2]) oHIT_PAD = 2'd3;
  end

  assign oSENSOR     = {17'h1FFFF, sens_q};
  assign oHIT_STB    = |pend_q;
  assign oHIT_CENTER = |(drain & cen_q);
  assign oLED        = led_q;
  assign unused_game = ^iOUT_GAME[31:3];
endmodule

// File: tb/tb_pad_sensor_frontend.sv
// Scoreboard bench: a window-based reference model predicts oSENSOR/oLED each
// cycle and queues expected hit events; a negedge monitor drains and compares.

module tb_pad_sensor_frontend;
  localparam int D = 4;
  localparam int H = 10;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n   = 1'b0;
  logic [14:0] iSENSOR_RAW = '1;
  logic [31:0] iOUT_GAME   = '1;
  logic [31:0] oSENSOR;
  logic        oHIT_STB;
  logic [1:0]  oHIT_PAD;
  logic        oHIT_CENTER;
  logic [2:0]  oLED;

  pad_sensor_frontend #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .iVGA_CLK   (iVGA_CLK),
    .iRST_n     (iRST_n),
    .iSENSOR_RAW(iSENSOR_RAW),
    .iOUT_GAME  (iOUT_GAME),
    .oSENSOR    (oSENSOR),
    .oHIT_STB   (oHIT_STB),
    .oHIT_PAD   (oHIT_PAD),
    .oHIT_CENTER(oHIT_CENTER),
    .oLED       (oLED)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  typedef struct packed { logic [1:0] pad; logic cen; } ev_t;
  ev_t exp_q[$];

  int tests = 0, fails = 0, n_stb = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: values it holds are those visible after the latest edge.
  logic [14:0] rh[$];
  logic [14:0] m_stable, m_held, m_sens, m_w;
  int          m_age[15];
  logic [2:0]  m_hitprev, m_pend, m_cen, m_tgt, m_led, m_h, m_rise, m_drain;
  bit          m_new;

  function automatic logic [14:0] rawh(int i);
    return (i < rh.size()) ? rh[i] : 15'h7FFF;
  endfunction

  function automatic logic [2:0] hit_of(logic [14:0] s);
    return {~&s[4:0], ~&s[9:5], ~&s[14:10]};
  endfunction

  task automatic m_reset();
    rh.delete();
    exp_q.delete();
    m_stable = '1; m_held = '1; m_sens = '1;
    for (int b = 0; b < 15; b++) m_age[b] = H;
    m_hitprev = '0; m_pend = '0; m_cen = '0; m_tgt = 3'b111; m_led = '0;
  endtask

  always @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) m_reset();
    else begin
      rh.push_front(iSENSOR_RAW);
      if (rh.size() > D + 2) void'(rh.pop_back());
      m_h     = hit_of(m_sens);
      m_rise  = m_h & ~m_hitprev;
      m_drain = m_pend[0] ? 3'b001 : m_pend[1] ? 3'b010 : m_pend[2] ? 3'b100 : 3'b000;
      for (int p = 0; p < 3; p++) if (m_rise[p]) m_cen[p] = ~m_sens[14 - 5 * p];
      m_pend    = (m_pend & ~m_drain) | m_rise;
      m_hitprev = m_h;
      m_led     = ~m_tgt & ~m_h;
      m_tgt     = iOUT_GAME[2:0];
      m_sens    = m_held;
      // A level is accepted once the synchronized input disagreed with it on D consecutive edges.
      for (int b = 0; b < 15; b++) begin
        m_new = 1'b1;
        for (int i = 0; i < D; i++) begin
          m_w = rawh(2 + i);
          if (m_w[b] == m_stable[b]) m_new = 1'b0;
        end
        m_w = rawh(2);
        if (m_age[b] < H) m_age[b]++;
        if (m_new) begin
          if (m_stable[b] && !m_w[b]) m_age[b] = 0;
          m_stable[b] = m_w[b];
        end
        m_held[b] = m_stable[b] && (m_age[b] >= H);
      end
      if (m_pend[0])      exp_q.push_back('{2'd1, m_cen[0]});
      else if (m_pend[1]) exp_q.push_back('{2'd2, m_cen[1]});
      else if (m_pend[2]) exp_q.push_back('{2'd3, m_cen[2]});
    end
  end

  always @(negedge iVGA_CLK) begin
    ev_t e;
    chk("sensor", oSENSOR, {17'h1FFFF, m_sens});
    chk("led", {29'd0, oLED}, {29'd0, m_led});
    if (oHIT_STB) begin
      n_stb++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("hit_pad", {30'd0, oHIT_PAD}, {30'd0, e.pad});
        chk("hit_center", {31'd0, oHIT_CENTER}, {31'd0, e.cen});
      end
    end else begin
      chk("idle_pad", {30'd0, oHIT_PAD}, 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_strobe_pad", 32'd0, {30'd0, e.pad});
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge iVGA_CLK);
    #1;
  endtask

  int s0;

  initial begin
    repeat (3) @(posedge iVGA_CLK);
    #1 iRST_n = 1'b1;
    tick(50);

    // Glitch shorter than the debounce window.
    s0 = n_stb;
    iSENSOR_RAW[4] = 1'b0; tick(3); iSENSOR_RAW[4] = 1'b1; tick(20);
    chk("glitch_strobes", n_stb - s0, 0);

    // Short accepted press: stretched to the hold width.
    s0 = n_stb;
    iSENSOR_RAW[4] = 1'b0; tick(6); iSENSOR_RAW[4] = 1'b1;
    tick(2);  chk("short_press_low", {31'd0, oSENSOR[4]}, 32'd0);
    tick(30); chk("short_press_strobes", n_stb - s0, 1);

    // Three pads at once drain over consecutive cycles.
    s0 = n_stb;
    iSENSOR_RAW[14] = 1'b0; iSENSOR_RAW[9] = 1'b0; iSENSOR_RAW[0] = 1'b0;
    tick(8); iSENSOR_RAW = '1; tick(30);
    chk("triple_strobes", n_stb - s0, 3);

    // LED follows target, dark while pad 1 is hit.
    iOUT_GAME = 32'hFFFF_FFFE; tick(2);
    chk("led_on", {29'd0, oLED}, 32'd1);
    iSENSOR_RAW[11] = 1'b0; tick(6); iSENSOR_RAW[11] = 1'b1;
    tick(6);  chk("led_dark_on_hit", {31'd0, oLED[0]}, 32'd0);
    tick(20); chk("led_relit", {31'd0, oLED[0]}, 32'd1);

    // Long press: one event, ring zone.
    s0 = n_stb;
    iSENSOR_RAW[12] = 1'b0; tick(40); iSENSOR_RAW[12] = 1'b1; tick(30);
    chk("long_press_strobes", n_stb - s0, 1);

    // Randomized: fast toggling (many glitches) then slower activity.
    for (int c = 0; c < 3000; c++) begin
      if (c < 1000) begin
        if ($urandom_range(0, 1) == 0) iSENSOR_RAW[$urandom_range(0, 14)] ^= 1'b1;
      end else if ($urandom_range(0, 7) == 0) iSENSOR_RAW[$urandom_range(0, 14)] ^= 1'b1;
      if (c % 37 == 0) iOUT_GAME = $urandom();
      tick(1);
    end
    iSENSOR_RAW = '1; tick(40);

    // Reset in the middle of a hold interval.
    iSENSOR_RAW[4] = 1'b0; tick(6); iSENSOR_RAW[4] = 1'b1; tick(4);
    chk("pre_reset_low", {31'd0, oSENSOR[4]}, 32'd0);
    iRST_n = 1'b0;
    #1;
    chk("reset_sensor", oSENSOR, 32'hFFFF_FFFF);
    chk("reset_stb", {31'd0, oHIT_STB}, 32'd0);
    chk("reset_led", {29'd0, oLED}, 32'd0);
    tick(2); iRST_n = 1'b1;
    tick(50);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
